// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory stage.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  // IDLE: sampling EX/MEM. WAIT: one data-memory access outstanding.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/Mux_2to1.sv
// Generic two-input mux: sel=0 picks in1, sel=1 picks in2.
module Mux_2to1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? in2 : in1;

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage pipeline: issues loads/stores over a req/ready
// handshake, stalls upstream while an access is in flight, and registers
// the MEM/WB values. The register-index width parameter is RD_WIDTH
// because RD_W is already the writeback-destination output port.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_WIDTH = RD_W_DEF,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_M,
  input  logic [DATA_W-1:0]   Alu_out_M,
  input  logic [DATA_W-1:0]   DM_WD_M,
  input  logic                DM_Write_M,
  input  logic                Result_M,
  input  logic                RF_WE_M,
  input  logic [RD_WIDTH-1:0] RD_M,
  output logic                stall_M,
  output logic                dm_req,
  output logic                dm_we,
  output logic [DATA_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W-1:0]   dm_rdata,
  input  logic                dm_ready,
  output logic [DATA_W-1:0]   Result_W,
  output logic                RF_WE_W,
  output logic [RD_WIDTH-1:0] RD_W,
  output logic                valid_W,
  output logic [CNT_W-1:0]    stall_count
);

  state_e              state_q, state_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [DATA_W-1:0]   dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  // Instruction fields captured at issue; upstream is frozen during WAIT
  // but these keep the completion independent of what EX/MEM shows then.
  logic                cap_load_q, cap_load_d;
  logic                cap_we_q, cap_we_d;
  logic [RD_WIDTH-1:0] cap_rd_q, cap_rd_d;
  logic [DATA_W-1:0]   cap_alu_q, cap_alu_d;
  logic [DATA_W-1:0]   res_w_q, res_w_d;
  logic                rfwe_w_q, rfwe_w_d;
  logic [RD_WIDTH-1:0] rd_w_q, rd_w_d;
  logic                valid_w_q, valid_w_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stall;
  logic                is_store, is_load, is_mem;
  logic [DATA_W-1:0]   mem_wb_val;

  // Store wins over load when both DM_Write_M and Result_M are set.
  assign is_store = valid_M & DM_Write_M;
  assign is_load  = valid_M & Result_M & ~DM_Write_M;
  assign is_mem   = is_store | is_load;

  Mux_2to1 #(.WIDTH(DATA_W)) u_wb_mux (
    .in1 (cap_alu_q),
    .in2 (dm_rdata),
    .sel (cap_load_q),
    .y   (mem_wb_val)
  );

  // Next-state, request, capture and MEM/WB selection.
  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    cap_load_d = cap_load_q;
    cap_we_d   = cap_we_q;
    cap_rd_d   = cap_rd_q;
    cap_alu_d  = cap_alu_q;
    res_w_d    = res_w_q;
    rd_w_d     = rd_w_q;
    rfwe_w_d   = 1'b0;
    valid_w_d  = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          stall      = 1'b1;
          dm_req_d   = 1'b1;
          dm_we_d    = is_store;
          dm_addr_d  = Alu_out_M;
          dm_wdata_d = DM_WD_M;
          cap_load_d = is_load;
          cap_we_d   = RF_WE_M;
          cap_rd_d   = RD_M;
          cap_alu_d  = Alu_out_M;
          state_d    = WAIT;
        end else if (valid_M) begin
          res_w_d   = Alu_out_M;
          rfwe_w_d  = RF_WE_M & (RD_M != '0);
          rd_w_d    = RD_M;
          valid_w_d = 1'b1;
        end
      end
      WAIT: begin
        stall = ~dm_ready;
        if (dm_ready) begin
          dm_req_d  = 1'b0;
          res_w_d   = mem_wb_val;
          rfwe_w_d  = cap_we_q & (cap_rd_q != '0);
          rd_w_d    = cap_rd_q;
          valid_w_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  // All state resets asynchronously so dm_req drops without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      cap_load_q <= 1'b0;
      cap_we_q   <= 1'b0;
      cap_rd_q   <= '0;
      cap_alu_q  <= '0;
      res_w_q    <= '0;
      rfwe_w_q   <= 1'b0;
      rd_w_q     <= '0;
      valid_w_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      cap_load_q <= cap_load_d;
      cap_we_q   <= cap_we_d;
      cap_rd_q   <= cap_rd_d;
      cap_alu_q  <= cap_alu_d;
      res_w_q    <= res_w_d;
      rfwe_w_q   <= rfwe_w_d;
      rd_w_q     <= rd_w_d;
      valid_w_q  <= valid_w_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stall_M     = stall;
  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign Result_W    = res_w_q;
  assign RF_WE_W     = rfwe_w_q;
  assign RD_W        = rd_w_q;
  assign valid_W     = valid_w_q;
  assign stall_count = cnt_q;

endmodule
